// File: rtl/bcd_conversor_rolhas_seq.sv
// Iterative binary-to-BCD converter (double-dabble) for the cork counting display path.
// Valid/ready on both sides. Overflow either saturates to all nines or wraps modulo 10^DIGITS.
module bcd_conversor_rolhas_seq #(
    parameter int WIDTH    = 7,
    parameter int DIGITS   = 2,
    parameter int SATURATE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int BW       = 4 * DIGITS;
    localparam int CNT_W    = $clog2(WIDTH + 1);
    localparam int CMP_W    = (WIDTH > 17) ? WIDTH : 17;
    localparam int MAX_INT  = 10**DIGITS - 1;
    localparam logic [CMP_W-1:0] MAX_VAL  = CMP_W'(MAX_INT);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_bin;
    logic [BW-1:0]      r_bcd;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;

    logic [BW-1:0]      w_adj;
    logic [BW-1:0]      w_bcd_next;
    logic [BW-1:0]      w_nines;
    logic               w_ovf_in;

    // Corrections look only at the pre-step digits, so there is no ripple between digits.
    always_comb begin
        w_adj = r_bcd;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5) begin
                w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
            end
        end
    end

    // The carry out of the top digit is dropped, which is what makes the result wrap modulo 10^DIGITS.
    assign w_bcd_next = {w_adj[BW-2:0], r_bin[WIDTH-1]};
    assign w_nines    = {DIGITS{4'h9}};
    assign w_ovf_in   = CMP_W'(bin_in) > MAX_VAL;

    // NOTE: every register here is written with <=, so all branches read the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            bcd_out   <= '0;
            overflow  <= 1'b0;
            r_bin     <= '0;
            r_bcd     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_bin    <= bin_in;
                        r_bcd    <= '0;
                        r_cnt    <= CNT_INIT;
                        r_ovf    <= w_ovf_in;
                        in_ready <= 1'b0;
                        r_state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_bcd <= w_bcd_next;
                    r_bin <= r_bin << 1;
                    r_cnt <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        bcd_out   <= (SATURATE != 0 && r_ovf) ? w_nines : w_bcd_next;
                        overflow  <= r_ovf;
                        out_valid <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conversor_rolhas_seq.sv
// Bench for bcd_conversor_rolhas_seq. Three configurations run side by side: defaults, wrap mode, and 10-bit/3-digit.
// Expected values come from decimal arithmetic on the input, not from a shift-and-add model.
module tb_bcd_conversor_rolhas_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [9:0]  bin_in = '0;

    logic        in_ready_a, out_valid_a, ovf_a;
    logic [7:0]  bcd_a;
    logic        in_ready_b, out_valid_b, ovf_b;
    logic [7:0]  bcd_b;
    logic        in_ready_c, out_valid_c, ovf_c;
    logic [11:0] bcd_c;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bcd_conversor_rolhas_seq #(.WIDTH(7), .DIGITS(2), .SATURATE(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .bin_in(bin_in[6:0]), .out_valid(out_valid_a), .out_ready(out_ready),
        .bcd_out(bcd_a), .overflow(ovf_a)
    );

    bcd_conversor_rolhas_seq #(.WIDTH(7), .DIGITS(2), .SATURATE(0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .bin_in(bin_in[6:0]), .out_valid(out_valid_b), .out_ready(out_ready),
        .bcd_out(bcd_b), .overflow(ovf_b)
    );

    bcd_conversor_rolhas_seq #(.WIDTH(10), .DIGITS(3), .SATURATE(1)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c),
        .bin_in(bin_in), .out_valid(out_valid_c), .out_ready(out_ready),
        .bcd_out(bcd_c), .overflow(ovf_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Decimal reference: saturate or wrap, then split into digits by division.
    function automatic logic [19:0] ref_bcd(input int n, input int d, input bit sat);
        int lim;
        int v;
        logic [19:0] r;
        lim = 1;
        for (int i = 0; i < d; i++) lim = lim * 10;
        if (sat && n > lim - 1) v = lim - 1;
        else                    v = n % lim;
        r = '0;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic start(input logic [9:0] n);
        int w;
        w = 0;
        @(negedge clk);
        while (!(in_ready_a && in_ready_b && in_ready_c) && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("start_ready", {31'd0, in_ready_a & in_ready_b & in_ready_c}, 1);
        bin_in   = n;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Called at the first negedge after the accepting edge, with out_ready high.
    task automatic collect(input logic [9:0] n);
        int lat_a, lat_b, lat_c;
        logic [7:0]  ga, gb;
        logic [11:0] gc;
        logic        oa, ob, oc;
        lat_a = -1; lat_b = -1; lat_c = -1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (out_valid_a && lat_a < 0) begin lat_a = k; ga = bcd_a; oa = ovf_a; end
            if (out_valid_b && lat_b < 0) begin lat_b = k; gb = bcd_b; ob = ovf_b; end
            if (out_valid_c && lat_c < 0) begin lat_c = k; gc = bcd_c; oc = ovf_c; end
            if (k == 8) begin
                check("idle_a_ready", {31'd0, in_ready_a}, 1);
                check("idle_a_valid", {31'd0, out_valid_a}, 0);
            end
            if (k == 11) check("idle_c_ready", {31'd0, in_ready_c}, 1);
        end
        check("lat_a", lat_a, 7);
        check("lat_b", lat_b, 7);
        check("lat_c", lat_c, 10);
        check("bcd_a", {24'd0, ga}, ref_bcd(int'(n[6:0]), 2, 1'b1));
        check("ovf_a", {31'd0, oa}, {31'd0, n[6:0] > 7'd99});
        check("bcd_b", {24'd0, gb}, ref_bcd(int'(n[6:0]), 2, 1'b0));
        check("ovf_b", {31'd0, ob}, {31'd0, n[6:0] > 7'd99});
        check("bcd_c", {20'd0, gc}, ref_bcd(int'(n), 3, 1'b1));
        check("ovf_c", {31'd0, oc}, {31'd0, n > 10'd999});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] rn;
        int waited;
        int q[$];
        int idx, last_acc, cyc, e;
        bit ghost;

        repeat (3) @(negedge clk);
        check("rst_ready_a", {31'd0, in_ready_a}, 1);
        check("rst_valid_a", {31'd0, out_valid_a}, 0);
        check("rst_bcd_a", {24'd0, bcd_a}, 0);
        check("rst_ovf_a", {31'd0, ovf_a}, 0);
        check("rst_ready_c", {31'd0, in_ready_c}, 1);
        check("rst_bcd_c", {20'd0, bcd_c}, 0);
        rst = 1'b0;

        // Directed corner values
        start(10'd99);   collect(10'd99);
        start(10'd100);  collect(10'd100);
        start(10'd127);  collect(10'd127);
        start(10'd0);    collect(10'd0);
        start(10'd1023); collect(10'd1023);
        start(10'd999);  collect(10'd999);
        start(10'd505);  collect(10'd505);

        // Random values
        repeat (12) begin
            rn = 10'($urandom_range(0, 1023));
            start(rn);
            collect(rn);
        end

        // Backpressure: result held, a waiting input only enters after release
        out_ready = 1'b0;
        start(10'd42);
        waited = 0;
        while (!out_valid_a && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("bp_valid_a", {31'd0, out_valid_a}, 1);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                bin_in   = 10'd33;
                in_valid = 1'b1;
            end
            @(negedge clk);
            check("bp_hold_bcd", {24'd0, bcd_a}, 32'h42);
            check("bp_hold_ready", {31'd0, in_ready_a}, 0);
            check("bp_hold_valid", {31'd0, out_valid_a}, 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", {31'd0, in_ready_a}, 1);
        check("bp_release_valid", {31'd0, out_valid_a}, 0);
        check("bp_keep_bcd", {24'd0, bcd_a}, 32'h42);
        @(negedge clk);
        in_valid = 1'b0;
        collect(10'd33);

        // Reset on the third shift edge discards the conversion
        start(10'd88);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_ready", {31'd0, in_ready_a}, 1);
        check("mid_rst_valid", {31'd0, out_valid_a}, 0);
        check("mid_rst_bcd", {24'd0, bcd_a}, 0);
        check("mid_rst_ovf", {31'd0, ovf_a}, 0);
        ghost = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid_a || out_valid_c) ghost = 1'b1;
        end
        check("mid_rst_no_output", {31'd0, ghost}, 0);
        start(10'd57);
        collect(10'd57);

        // Back-to-back sweep 0..127 through the 7-bit converters
        idx = 0; last_acc = -1; cyc = 0;
        while ((idx < 128 || q.size() > 0) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (out_valid_a) begin
                if (q.size() == 0) begin
                    check("sweep_extra_output", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("sweep_bcd_a", {24'd0, bcd_a}, ref_bcd(e, 2, 1'b1));
                    check("sweep_ovf_a", {31'd0, ovf_a}, {31'd0, e > 99});
                    check("sweep_valid_b", {31'd0, out_valid_b}, 1);
                    check("sweep_bcd_b", {24'd0, bcd_b}, ref_bcd(e, 2, 1'b0));
                end
            end
            if (in_ready_a && idx < 128) begin
                bin_in   = 10'(idx);
                in_valid = 1'b1;
                q.push_back(idx);
                if (last_acc >= 0) check("sweep_throughput", cyc - last_acc, 9);
                last_acc = cyc;
                idx++;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check("sweep_all_issued", idx, 128);
        check("sweep_all_returned", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_conversor_rolhas_seq.md
Name: bcd_conversor_rolhas_seq

Overview:
- Parametrised sequential binary-to-BCD converter for the cork ("rolhas") counting path.
- Generalises the fixed 7-bit tens-digit encoder into WIDTH-bit input / DIGITS-digit output.
- Uses an iterative shift-and-add-3 (double-dabble) datapath with valid/ready handshakes and overflow detection with selectable saturate or modulo behaviour.
- Sits between the cork counter and the 7-segment digit decoders.

Parameters:
- WIDTH, 7: binary input width. Legal range is 1..16.
- DIGITS, 2: number of BCD output digits. Legal range is 1..5.
- SATURATE, 1: overflow handling. 1 forces all-nines output; 0 returns bin_in mod 10^DIGITS.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  bin_in is valid
- in_ready  output  1  converter can accept an input
- bin_in  input  WIDTH  unsigned binary count
- out_valid  output  1  bcd_out and overflow are valid
- out_ready  input  1  consumer accepts the result
- bcd_out  output  4*DIGITS  packed BCD; digit k is bits [4k+3:4k], digit 0 is units
- overflow  output  1  bin_in was greater than 10^DIGITS-1

Behaviour:
- Reset: rst sampled high at a rising edge gives:
  - state=IDLE, in_ready=1, out_valid=0, bcd_out=0, overflow=0.
  - The shift register and counter are cleared.
  - rst overrides every other input, including mid-conversion and while out_valid is held. An in-flight conversion is discarded with no output.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1:
    - Latch bin_in into the binary shift register.
    - Clear the BCD accumulator.
    - Set counter=WIDTH.
    - Register ovf = (bin_in > 10^DIGITS-1). MAX is an elaboration-time constant.
    - Go to SHIFT.
- SHIFT:
  - in_ready=0. in_valid is ignored.
  - Each edge performs one step:
    - Every BCD digit that is ≥5 gets +3.
    - Then {bcd, bin} shifts left by 1.
    - The bit shifted out of the top digit is discarded, which yields mod 10^DIGITS.
    - counter decrements.
  - The edge on which counter goes 1→0 moves to DONE.
  - At that edge, bcd_out is loaded with:
    - SATURATE=1 and ovf=1: 4'h9 in every digit.
    - Otherwise: the accumulator.
  - overflow is loaded with ovf, and out_valid is set to 1.
- DONE:
  - out_valid=1. bcd_out and overflow are held stable until out_ready=1.
  - On an edge with out_ready=1: out_valid goes to 0 and the state returns to IDLE. bcd_out and overflow keep their last values.
  - in_ready=0 in DONE; there is no overlap.
- Latency: out_valid rises WIDTH edges after the accepting edge, the same cycle as the last shift.
- Throughput: one conversion per WIDTH+2 cycles when out_ready is held high.
- Simultaneous events:
  - in_valid held high through DONE is accepted only in the IDLE cycle that follows.
  - out_ready outside DONE has no effect.
- Digit corrections in a step use the pre-step digit values only; they do not ripple within a cycle.
- Width rule: ovf uses a comparison at least max(WIDTH,17) bits wide so that 10^DIGITS never truncates. With WIDTH=7 and DIGITS≥3, ovf is constant 0.

Test Plan:
- Defaults (W=7, D=2, SAT=1):
  - bin_in=99, then hold out_ready=1 → out_valid high 7 edges after accept, bcd_out=8'h99, overflow=0, back to IDLE one cycle later.
  - bin_in=100 → bcd_out=8'h99, overflow=1.
  - bin_in=127 → bcd_out=8'h99, overflow=1.
  - bin_in=0 → bcd_out=8'h00, overflow=0.
- SAT=0, W=7, D=2: bin_in=100 → bcd_out=8'h00, overflow=1. bin_in=127 → 8'h27, overflow=1.
- W=10, D=3, SAT=1: bin_in=1023 → 12'h999, overflow=1. bin_in=999 → 12'h999, overflow=0. bin_in=505 → 12'h505, overflow=0. All three with latency 10 edges.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid on bin_in=42 (defaults) → bcd_out stays 8'h42, in_ready stays 0, and a second in_valid pulse is not accepted. Release → next input is accepted on the IDLE cycle.
- Reset mid-op: assert rst at the 3rd SHIFT edge → next cycle IDLE, in_ready=1, out_valid=0, bcd_out=0. A following bin_in=57 yields 8'h57 with normal latency.
- Exhaustive sweep with defaults: all 0..127 back-to-back → each result equals the BCD of min(n,99), and overflow=(n>99).
